// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path fed by the core's uart_out port.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_STROBE_BIT = 8;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-write strobe from the core plus the serial line and status flags back out.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic [UART_STROBE_BIT:0] uart_in;
  logic                     tx;
  logic                     tx_busy;
  logic                     fifo_full;
  logic                     overflow;

  modport master (
    output uart_in,
    input  tx,
    input  tx_busy,
    input  fifo_full,
    input  overflow
  );

  modport slave (
    input  uart_in,
    output tx,
    output tx_busy,
    output fifo_full,
    output overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a combinational head read and a registered occupancy counter.
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers byte writes from the core and sends them as 8N1 serial frames on tx.
// Strobes arriving while the FIFO is full are dropped and latch the sticky overflow flag.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input logic                 clock,
  input logic                 reset_n,
  uart_tx_serializer_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e               state;
  uart_state_e               state_next;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      strobe;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      bit_end;
  logic                      tx_next;
  logic                      tx_reg;
  logic                      busy_reg;
  logic                      overflow_reg;

  assign strobe  = bus.uart_in[UART_STROBE_BIT];
  assign bit_end = (baud_cnt == BAUD_LAST);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push    = strobe && (!fifo_full || pop);
  assign drop    = strobe && fifo_full && !pop;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.uart_in[UART_DATA_BITS-1:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_cnt == BIT_LAST)) state_next = STOP;
      STOP:    if (bit_end) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // The STOP-end pop chains the next frame straight into START with no idle gap.
  always_comb begin
    pop     = 1'b0;
    tx_next = 1'b1;
    case (state)
      IDLE:    pop = !fifo_empty;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      STOP:    pop = bit_end && !fifo_empty;
      default: tx_next = 1'b1;
    endcase
  end

  // tx and busy lag the state by one cycle so the line is always driven from a flop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      tx_reg   <= tx_next;
      busy_reg <= (state != IDLE) || !fifo_empty;
      if (drop) overflow_reg <= 1'b1;
      if (pop) begin
        shift_reg <= fifo_head;
        bit_cnt   <= '0;
        baud_cnt  <= '0;
      end else if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (bit_end) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign bus.tx        = tx_reg;
  assign bus.tx_busy   = busy_reg || (fifo_count != '0);
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: per-cycle frame checks from a vector table,
// plus a negedge-sampling serial receiver for the back-to-back and overflow sequences.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] exp_frame;
  } frame_vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic       rx_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         rx_bad_stop = 0;

  frame_vec_t vecs[5];

  uart_tx_serializer_if dut_if ();

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dut_if.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Serial receiver: finds the start bit, then samples mid-bit LSB first.
  initial begin : rx_model
    logic [7:0] rx_byte;
    rx_byte = '0;
    forever begin
      @(negedge clock);
      if (rx_en && dut_if.tx === 1'b0) begin
        rx_start.push_back(cyc);
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < UART_DATA_BITS; i++) begin
          repeat (CPB) @(negedge clock);
          rx_byte = {dut_if.tx, rx_byte[7:1]};
        end
        repeat (CPB) @(negedge clock);
        if (dut_if.tx !== 1'b1) rx_bad_stop++;
        rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic strobe, input logic [7:0] data);
    dut_if.uart_in = {strobe, data};
  endtask

  task automatic check_idle(input string name);
    check_bit({name, " tx"},        dut_if.tx,        1'b1);
    check_bit({name, " tx_busy"},   dut_if.tx_busy,   1'b0);
    check_bit({name, " fifo_full"}, dut_if.fifo_full, 1'b0);
    check_bit({name, " overflow"},  dut_if.overflow,  1'b0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    apply_stimulus(1'b1, 8'hFF);
    repeat (3) tick();
    reset_n = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    tick();
  endtask

  // Strobe one byte from idle and check every cycle of the resulting frame.
  task automatic send_and_check(input frame_vec_t v);
    logic [9:0] fr;
    fr = v.exp_frame;
    apply_stimulus(1'b1, v.data);
    tick();
    apply_stimulus(1'b0, 8'h00);
    check_bit({v.name, " busy on push"}, dut_if.tx_busy, 1'b1);
    check_bit({v.name, " tx at push"},   dut_if.tx,      1'b1);
    tick();
    check_bit({v.name, " tx at pop"},    dut_if.tx,      1'b1);
    for (int b = 0; b < UART_FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        check_bit($sformatf("%s bit%0d cyc%0d", v.name, b, c), dut_if.tx, fr[0]);
      end
      fr = fr >> 1;
    end
    check_bit({v.name, " busy last stop"}, dut_if.tx_busy, 1'b1);
    tick();
    check_bit({v.name, " busy after"}, dut_if.tx_busy, 1'b0);
    check_bit({v.name, " tx after"},   dut_if.tx,      1'b1);
  endtask

  initial begin : main
    // Expected frames are {stop, data[7:0], start} = {1, byte, 0}, sent LSB first.
    vecs[0] = '{"byte 0x55", 8'h55, 10'b1_0101_0101_0};
    vecs[1] = '{"byte 0x00", 8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{"byte 0xFF", 8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{"byte 0xA3", 8'hA3, 10'b1_1010_0011_0};
    vecs[4] = '{"byte 0x01", 8'h01, 10'b1_0000_0001_0};

    apply_reset();
    check_idle("reset");

    for (int i = 0; i < 5; i++) begin
      send_and_check(vecs[i]);
      repeat (3) tick();
    end

    // Three consecutive strobes: back-to-back frames 40 cycles apart.
    rx_q.delete();
    rx_start.delete();
    rx_bad_stop = 0;
    rx_en = 1'b1;
    apply_stimulus(1'b1, 8'h41); tick();
    apply_stimulus(1'b1, 8'h42); tick();
    apply_stimulus(1'b1, 8'h43); tick();
    apply_stimulus(1'b0, 8'h00);
    repeat (130) tick();
    check_output("abc count",   rx_q.size(), 3);
    check_output("abc byte0",   int'(rx_q[0]), 32'h41);
    check_output("abc byte1",   int'(rx_q[1]), 32'h42);
    check_output("abc byte2",   int'(rx_q[2]), 32'h43);
    check_output("abc gap01",   rx_start[1] - rx_start[0], 40);
    check_output("abc gap12",   rx_start[2] - rx_start[1], 40);
    check_output("abc stopbits", rx_bad_stop, 0);
    check_bit("abc busy after", dut_if.tx_busy, 1'b0);

    // Six strobes into a 4-deep FIFO: one popped, four queued, the last dropped.
    rx_q.delete();
    rx_bad_stop = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 8'h31 + 8'(i));
      tick();
      if (i == 4) begin
        check_bit("ovf full at 5th", dut_if.fifo_full, 1'b1);
        check_bit("ovf clear at 5th", dut_if.overflow, 1'b0);
      end
    end
    apply_stimulus(1'b0, 8'h00);
    check_bit("ovf full at 6th", dut_if.fifo_full, 1'b1);
    check_bit("ovf set at 6th",  dut_if.overflow,  1'b1);
    for (int f = 0; f < 5; f++) begin
      repeat (40) tick();
      check_bit($sformatf("ovf sticky frame%0d", f), dut_if.overflow, 1'b1);
    end
    repeat (20) tick();
    check_output("ovf count", rx_q.size(), 5);
    check_output("ovf first", int'(rx_q[0]), 32'h31);
    check_output("ovf last",  int'(rx_q[4]), 32'h35);
    check_output("ovf stopbits", rx_bad_stop, 0);
    check_bit("ovf busy after", dut_if.tx_busy,   1'b0);
    check_bit("ovf full after", dut_if.fifo_full, 1'b0);

    apply_reset();
    check_idle("reset after ovf");

    // Full FIFO with a strobe landing exactly on the STOP-end pop edge.
    rx_q.delete();
    rx_bad_stop = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'h61 + 8'(i));
      tick();
    end
    apply_stimulus(1'b0, 8'h00);
    check_bit("popcyc full",      dut_if.fifo_full, 1'b1);
    repeat (36) tick();
    check_bit("popcyc full pre",  dut_if.fifo_full, 1'b1);
    apply_stimulus(1'b1, 8'h66);
    tick();
    apply_stimulus(1'b0, 8'h00);
    check_bit("popcyc full post", dut_if.fifo_full, 1'b1);
    check_bit("popcyc no ovf",    dut_if.overflow,  1'b0);
    repeat (215) tick();
    check_output("popcyc count", rx_q.size(), 6);
    check_output("popcyc first", int'(rx_q[0]), 32'h61);
    check_output("popcyc last",  int'(rx_q[5]), 32'h66);
    check_bit("popcyc ovf end",  dut_if.overflow, 1'b0);
    check_bit("popcyc busy end", dut_if.tx_busy,  1'b0);

    // Reset during data bit 3 with a full FIFO and overflow already set.
    rx_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 8'h00);
      tick();
    end
    apply_stimulus(1'b0, 8'h00);
    check_bit("midrst ovf pre", dut_if.overflow, 1'b1);
    repeat (14) tick();
    check_bit("midrst tx bit3", dut_if.tx, 1'b0);
    reset_n = 1'b0;
    apply_stimulus(1'b1, 8'hAA);
    tick();
    check_idle("midrst");
    reset_n = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("midrst tx hold%0d", i),   dut_if.tx,      1'b1);
      check_bit($sformatf("midrst busy hold%0d", i), dut_if.tx_busy, 1'b0);
    end
    send_and_check('{"post-reset 0x5A", 8'h5A, 10'b1_0101_1010_0});

    // Data without the strobe bit must never reach the line.
    apply_stimulus(1'b0, 8'hFF);
    for (int i = 0; i < 100; i++) begin
      tick();
      check_bit($sformatf("nostrobe tx c%0d", i),   dut_if.tx,      1'b1);
      check_bit($sformatf("nostrobe busy c%0d", i), dut_if.tx_busy, 1'b0);
    end
    apply_stimulus(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
